// File: rtl/sda_shift_xcvr.sv
// Half-duplex single-wire shift transceiver: shifts a WIDTH-bit word out on, or in from,
// a shared tristate sda line, one bit every BIT_DIV clocks, with start/busy/done handshake.
module sda_shift_xcvr #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int BIT_DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             oe,
    inout  wire              sda
);

    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(BIT_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic             dir_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] tx_shifted, rx_shifted;
    logic             out_bit, sda_o;
    logic             div_wrap, div_sample, last_wrap;

    assign div_wrap   = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    assign div_sample = (state == S_SHIFT) && (div_cnt == DIV_SAMPLE);
    assign last_wrap  = div_wrap && (bit_cnt == BIT_LAST);

    // The output end of the shift register is the end that goes on the wire first.
    always_comb begin
        if (MSB_FIRST != 0) begin
            out_bit    = shreg[WIDTH-1];
            tx_shifted = {shreg[WIDTH-2:0], 1'b0};
            rx_shifted = {shreg[WIDTH-2:0], sda};
        end else begin
            out_bit    = shreg[0];
            tx_shifted = {1'b0, shreg[WIDTH-1:1]};
            rx_shifted = {sda, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        shreg_nxt = shreg;
        case (state)
            S_IDLE:  if (start) shreg_nxt = tx_data;
            S_SHIFT: begin
                if (dir_q) begin
                    if (div_wrap) shreg_nxt = tx_shifted;
                end else if (div_sample) begin
                    shreg_nxt = rx_shifted;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last_wrap) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q   <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            rx_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dir_q   <= dir;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) bit_cnt <= last_wrap ? '0 : bit_cnt + BIT_W'(1);
                    // With BIT_DIV=2 the final sample lands on the same edge as the last wrap.
                    if (last_wrap && !dir_q) rx_data <= shreg_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        oe    = (state == S_SHIFT) && dir_q;
        sda_o = oe ? out_bit : 1'b1;
    end

    assign sda = oe ? sda_o : 1'bz;

endmodule

// File: tb/tb_sda_shift_xcvr.sv
// Bench for sda_shift_xcvr: three instances (MSB-first/8/4, LSB-first/8/4, MSB-first/4/2)
// driven by directed and random transfers, checked against a bit-position reference model.
`timescale 1ns/1ps
module tb_sda_shift_xcvr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       go  = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] tx  = 8'h00;
    logic       tb_sda = 1'b1;
    int         sel = 0;

    wire        sda_a, sda_b, sda_c;
    logic [7:0] rx_a, rx_b;
    logic [3:0] rx_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, oe_a, oe_b, oe_c;

    sda_shift_xcvr #(.WIDTH(8), .MSB_FIRST(1), .BIT_DIV(4)) u_a (
        .clk(clk), .rst(rst), .start(go && sel == 0), .dir(dir), .tx_data(tx),
        .rx_data(rx_a), .busy(busy_a), .done(done_a), .oe(oe_a), .sda(sda_a));
    sda_shift_xcvr #(.WIDTH(8), .MSB_FIRST(0), .BIT_DIV(4)) u_b (
        .clk(clk), .rst(rst), .start(go && sel == 1), .dir(dir), .tx_data(tx),
        .rx_data(rx_b), .busy(busy_b), .done(done_b), .oe(oe_b), .sda(sda_b));
    sda_shift_xcvr #(.WIDTH(4), .MSB_FIRST(1), .BIT_DIV(2)) u_c (
        .clk(clk), .rst(rst), .start(go && sel == 2), .dir(dir), .tx_data(tx[3:0]),
        .rx_data(rx_c), .busy(busy_c), .done(done_c), .oe(oe_c), .sda(sda_c));

    // The bench acts as the remote end and pull-up whenever the DUT releases the line.
    assign sda_a = oe_a ? 1'bz : tb_sda;
    assign sda_b = oe_b ? 1'bz : tb_sda;
    assign sda_c = oe_c ? 1'bz : tb_sda;

    logic       m_busy, m_done, m_oe, m_sda;
    logic [7:0] m_rx;
    always_comb begin
        m_busy = busy_a; m_done = done_a; m_oe = oe_a; m_sda = sda_a; m_rx = rx_a;
        if (sel == 1) begin
            m_busy = busy_b; m_done = done_b; m_oe = oe_b; m_sda = sda_b; m_rx = rx_b;
        end else if (sel == 2) begin
            m_busy = busy_c; m_done = done_c; m_oe = oe_c; m_sda = sda_c; m_rx = {4'h0, rx_c};
        end
    end

    int         total  = 0;
    int         passes = 0;
    logic [7:0] rx_model [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, sel, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int w_of(input int s);
        return (s == 2) ? 4 : 8;
    endfunction

    function automatic int d_of(input int s);
        return (s == 2) ? 2 : 4;
    endfunction

    // Serial bit i of a word: counted from the MSB or the LSB depending on instance bit order.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int w = w_of(sel);
        return (sel == 1) ? d[i] : d[w-1-i];
    endfunction

    function automatic logic [7:0] mask_w(input logic [7:0] d);
        return (w_of(sel) == 8) ? d : (d & 8'h0F);
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) rx_model[s] = 8'h00;
    endtask

    task automatic run_tx(input logic [7:0] data_in, input bit extra_start);
        int w = w_of(sel);
        int dd = d_of(sel);
        logic [7:0] data = mask_w(data_in);
        go = 1'b1; dir = 1'b1; tx = data;
        tick();
        go = 1'b0;
        for (int c = 0; c < w * dd; c++) begin
            check("tx_bit", {m_busy, m_oe, m_done, m_sda}, {1'b1, 1'b1, 1'b0, exp_bit(data, c / dd)});
            if (extra_start && c == 9) begin
                go = 1'b1; dir = 1'b0; tx = ~data;
            end else if (extra_start && c == 10) begin
                go = 1'b0; dir = 1'b1; tx = data;
            end
            tick();
        end
        check("tx_done", {m_busy, m_oe, m_done}, 3'b101);
        check("tx_rx_hold", m_rx, rx_model[sel]);
        tick();
        check("tx_idle", {m_busy, m_oe, m_done}, 3'b000);
    endtask

    task automatic run_rx(input logic [7:0] data_in, input bit glitch);
        int w = w_of(sel);
        int dd = d_of(sel);
        logic [7:0] data = mask_w(data_in);
        logic b;
        go = 1'b1; dir = 1'b0; tx = 8'($urandom);
        tick();
        go = 1'b0;
        for (int c = 0; c < w * dd; c++) begin
            b = exp_bit(data, c / dd);
            tb_sda = (glitch && (c % dd) == 0) ? ~b : b;
            check("rx_busy", {m_busy, m_oe, m_done}, 3'b100);
            tick();
        end
        tb_sda = 1'b1;
        check("rx_done", {m_busy, m_oe, m_done}, 3'b101);
        check("rx_data", m_rx, data);
        rx_model[sel] = data;
        tick();
        check("rx_idle", {m_busy, m_oe, m_done}, 3'b000);
        check("rx_hold", m_rx, data);
    endtask

    initial begin
        int seen;
        for (int s = 0; s < 3; s++) rx_model[s] = 8'h00;
        do_reset(3);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_ctl", {m_busy, m_oe, m_done}, 3'b000);
            check("reset_rx", m_rx, 8'h00);
        end

        sel = 0;
        run_tx(8'hA5, 1'b0);
        run_rx(8'h3C, 1'b0);
        run_tx(8'($urandom), 1'b0);

        sel = 1;
        run_tx(8'h1E, 1'b0);
        run_rx(8'h1E, 1'b0);

        sel = 0;
        run_tx(8'h6B, 1'b1);
        run_tx(8'hC3, 1'b0);

        // Reset in the middle of a transmit discards it and clears rx_data.
        go = 1'b1; dir = 1'b1; tx = 8'hFF;
        tick();
        go = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) rx_model[s] = 8'h00;
        check("rst_mid_ctl", {m_busy, m_oe, m_done}, 3'b000);
        check("rst_mid_rx", m_rx, 8'h00);
        seen = 0;
        repeat (40) begin
            if (m_done) seen++;
            tick();
        end
        check("rst_no_done", seen, 0);
        run_tx(8'h81, 1'b0);

        run_rx(8'h5A, 1'b0);
        go = 1'b1; rst = 1'b1; dir = 1'b1; tx = 8'h55;
        tick();
        go = 1'b0; rst = 1'b0;
        for (int s = 0; s < 3; s++) rx_model[s] = 8'h00;
        check("rst_start_ctl", {m_busy, m_oe, m_done}, 3'b000);
        check("rst_start_rx", m_rx, 8'h00);
        tick();
        check("rst_start_idle", {m_busy, m_oe}, 2'b00);

        sel = 2;
        run_rx(8'h09, 1'b1);
        run_tx(8'h0D, 1'b0);

        for (int n = 0; n < 10; n++) begin
            sel = int'($urandom_range(0, 2));
            #1;
            if ($urandom_range(0, 1) == 1) run_tx(8'($urandom), 1'b0);
            else                           run_rx(8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
